edib_mode2_rx: RTL and testbench
================================

// Module: edib_mode2_rx
// PURPOSE
//  Receiver for the EDIB mode-2 serial link, the far end of the mode-2 transmit bit clock (12 MHz / 144 = 83.333 kbit/s).
//  Oversamples rx_in on clk_12m, finds the start of each frame, samples every bit at mid-period
//  and delivers a 16-bit word with a one-cycle valid strobe plus parity and framing error flags.
//  Sits between the board RX pin and the EDIB command decoder.
// PARAMETERS
//  BIT_CYCLES  144  clk_12m cycles per bit; legal range 8..255
//  HALF        72   mid-bit offset; must equal BIT_CYCLES/2
//  DATA_BITS   16   payload bits per frame, MSB first; legal range 1..31
// PORTS
//  clk_12m     in   1          12 MHz system clock; all logic is on the rising edge
//  reset       in   1          asynchronous, active-low reset
//  rx_in       in   1          serial line; idle high; asynchronous to clk_12m
//  rx_data     out  DATA_BITS  last received word
//  rx_valid    out  1          1-cycle strobe; rx_data holds the new word on this cycle
//  parity_err  out  1          1-cycle strobe, coincident with rx_valid; odd parity failed
//  frame_err   out  1          1-cycle strobe; stop bit sampled low
//  rx_busy     out  1          high in every state except IDLE
// BEHAVIOUR
//  Frame: start(0), DATA_BITS data bits MSB first, parity bit, stop(1).
//   Parity is odd: the data bits plus the parity bit contain an odd number of 1s.
//  Input: 2-flop synchronizer gives rx_s; rx_s_d is rx_s delayed one cycle. Both reset to 1.
//  Counters: bit-phase counter cnt is 8 bits; bit index idx is 5 bits; both reset to 0.
//  Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0, state=IDLE.
//  FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
//  IDLE: when rx_s=0 and rx_s_d=1 (falling edge, detect cycle D), go to START and clear cnt.
//  START: at cnt=HALF-1 (D+72) take the bit value.
//   Value 1: false start (glitch); go to IDLE with no strobe.
//   Value 0: go to DATA; clear cnt and idx.
//  DATA: each time cnt=BIT_CYCLES-1, restart cnt and shift the bit value into the shift register.
//   After idx=DATA_BITS-1, go to PARITY.
//  PARITY: sample after one further BIT_CYCLES, then go to STOP.
//  STOP: sample after one further BIT_CYCLES.
//   Value 1: next cycle, load rx_data from the shift register and pulse rx_valid.
//    parity_err pulses in the same cycle if parity failed.
//    Go to IDLE.
//   Value 0: pulse frame_err. rx_data is unchanged and rx_valid stays 0. Go to WAIT_IDLE.
//  WAIT_IDLE: stay until rx_s=1, then go to IDLE. A held-low (break) line therefore raises no new frames.
//  Latency: stop sample at D+72+(DATA_BITS+2)*144 = D+2664; rx_valid at D+2665 (default parameters).
//   Add 2 cycles of synchronizer delay from the rx_in pin.
//  Back-to-back frames: a start edge one cycle after rx_valid is accepted. No dead time beyond returning to IDLE.
//  A falling edge seen outside IDLE is ignored. The bit timing is not resynchronized within a frame.
//  rx_valid and frame_err are never high in the same cycle.
//  Reset asserted mid-frame: every output returns to its reset value at once; the partial word is discarded.
//   After release, the receiver waits in IDLE for a fresh falling edge.
// CONFIGURATION
//  EDIB_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of rx_s at cnt=HALF-2, HALF-1 and HALF.
//   The decision is taken at cnt=HALF, so every sample point and rx_valid move +1 cycle (rx_valid at D+2666).
//   A 1-cycle glitch at the sample point is rejected.
//  EDIB_RX_MAJORITY_EN undefined: bit value is rx_s at cnt=HALF-1 only.
// TESTING
//  1 Send 0xA55A with parity=1, stop=1 -> rx_data=0xA55A, rx_valid 1 cycle at D+2665, parity_err=0, frame_err=0.
//  2 Send 0x0001 with parity=1 (wrong) -> rx_valid with rx_data=0x0001 and parity_err=1 in the same cycle.
//  3 Drive a 30-cycle low glitch on an idle line -> no strobe; rx_busy high about 72 cycles, then IDLE.
//  4 Send 0x1234 with stop=0 and hold the line low 500 cycles -> frame_err 1 cycle; rx_data unchanged.
//    No further strobes until the line goes high and a new frame 0x00FF is received correctly.
//  5 Assert reset at bit 7 of a frame -> all outputs 0 immediately; the next full frame 0xBEEF is received correctly.
//  6 Send back-to-back frames 0xFFFF and 0x8000 with zero idle -> two rx_valid strobes 2736 cycles apart.
//    With EDIB_RX_MAJORITY_EN, a 1-cycle inverted glitch at each mid-bit is rejected and data is still correct.

Source files
------------

// File: rtl/edib_mode2_rx.sv
// edib_mode2_rx: EDIB mode-2 serial receiver.
// Oversamples rx_in on clk_12m, locks onto the falling start edge and samples
// each bit at mid-period. It then delivers a DATA_BITS word, MSB first, with
// an odd-parity check and a stop-bit framing check.
// Frame on the wire: start(0), DATA_BITS data bits, parity, stop(1).
// Build option: define EDIB_RX_MAJORITY_EN to decide each bit by a 2-of-3
// vote around the mid-bit point. This moves every decision one cycle later.
module edib_mode2_rx #(
  parameter int unsigned BIT_CYCLES = 144,
  parameter int unsigned HALF       = 72,
  parameter int unsigned DATA_BITS  = 16
) (
  input  logic                 clk_12m,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 5;

`ifdef EDIB_RX_MAJORITY_EN
  // The vote spans HALF-2..HALF, so the start decision lands at HALF.
  localparam int unsigned START_PT = HALF;
`else
  localparam int unsigned START_PT = HALF - 1;
`endif

  localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_PT);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t                 state;
  logic                   rx_m;
  logic                   rx_s;
  logic                   rx_s_d;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   bit_val_c;
  logic                   fall_c;

  // Two-flop synchronizer for the asynchronous pin, plus one delay for edge detect.
  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx_in;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign fall_c = rx_s_d & ~rx_s;

`ifdef EDIB_RX_MAJORITY_EN
  logic [1:0] hist;

  // Two most recent synchronized samples for the 2-of-3 vote.
  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_val_c = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val_c = rx_s;
`endif

  // Frame FSM with bit-phase counter, shift register and registered strobes.
  always_ff @(posedge clk_12m or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (fall_c) begin
            state   <= START;
            cnt     <= '0;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == START_CNT) begin
            if (bit_val_c) begin
              // Line back high at mid-start: glitch, not a frame.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end
          end else begin
            cnt <= CNT_W'(cnt + 1'b1);
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            shreg <= DATA_BITS'({shreg, bit_val_c});
            idx   <= IDX_W'(idx + 1'b1);
            if (idx == LAST_IDX) begin
              state <= PARITY;
            end
          end else begin
            cnt <= CNT_W'(cnt + 1'b1);
          end
        end
        PARITY: begin
          if (cnt == LAST_CNT) begin
            cnt     <= '0;
            par_bit <= bit_val_c;
            state   <= STOP;
          end else begin
            cnt <= CNT_W'(cnt + 1'b1);
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt <= '0;
            if (bit_val_c) begin
              rx_data    <= shreg;
              rx_valid   <= 1'b1;
              // Odd parity: data plus parity bit must hold an odd count of ones.
              parity_err <= ~(^{shreg, par_bit});
              state      <= IDLE;
              rx_busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= CNT_W'(cnt + 1'b1);
          end
        end
        WAIT_IDLE: begin
          // A held-low line must return high before a new start is armed.
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edib_mode2_rx.sv
// tb_edib_mode2_rx: directed bench for edib_mode2_rx at default parameters.
// Expected cycle numbers count from the clock interval in which the start bit
// is first driven on rx_in. That point is 2 synchronizer cycles ahead of the
// detect cycle.
module tb_edib_mode2_rx;

  localparam int unsigned BITC = 144;
  localparam int unsigned FRAME = 19 * BITC;
`ifdef EDIB_RX_MAJORITY_EN
  localparam int unsigned LAT = 2668;
  localparam int unsigned BUSY_GLITCH = 73;
  localparam bit GL = 1'b1;
`else
  localparam int unsigned LAT = 2667;
  localparam int unsigned BUSY_GLITCH = 72;
  localparam bit GL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_in = 1'b1;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        rx_busy;

  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    int unsigned cyc;
    logic [15:0] data;
    logic        perr;
    logic        ferr;
    logic        vld;
  } ev_t;
  ev_t evq[$];

  edib_mode2_rx dut (
    .clk_12m    (clk),
    .reset      (reset),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record every strobe cycle; a strobe wider than one cycle shows up as extra entries.
  always @(negedge clk) begin
    if (reset && (rx_valid || frame_err)) begin
      evq.push_back('{cyc, rx_data, parity_err, frame_err, rx_valid});
      check("valid_frame_excl", 32'(rx_valid & frame_err), 32'd0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit period; with glitch set, the pin is inverted for the single mid-bit cycle.
  task automatic drive_bit(input logic b, input bit glitch);
    rx_in = b;
    if (glitch) begin
      wait_cyc(72);
      rx_in = ~b;
      wait_cyc(1);
      rx_in = b;
      wait_cyc(71);
    end else begin
      wait_cyc(BITC);
    end
  endtask

  task automatic send_frame(input logic [15:0] d, input logic par, input logic stp, input bit glitch);
    drive_bit(1'b0, glitch);
    for (int i = 15; i >= 0; i--) drive_bit(d[i], glitch);
    drive_bit(par, glitch);
    drive_bit(stp, glitch);
  endtask

  task automatic check_ev(input string tag, input int k, input int unsigned cyc_exp,
                          input logic [15:0] d, input logic p, input logic f, input logic v);
    if (k < evq.size()) begin
      check({tag, "_cycle"}, evq[k].cyc, cyc_exp);
      check({tag, "_data"}, 32'(evq[k].data), 32'(d));
      check({tag, "_perr"}, 32'(evq[k].perr), 32'(p));
      check({tag, "_ferr"}, 32'(evq[k].ferr), 32'(f));
      check({tag, "_valid"}, 32'(evq[k].vld), 32'(v));
    end else begin
      check({tag, "_present"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    int unsigned c;
    int unsigned c2;
    int          busy_cnt;

    // Reset state
    wait_cyc(3);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    reset = 1'b1;
    wait_cyc(10);
    check("idle_busy", 32'(rx_busy), 32'd0);

    // 1: good frame 0xA55A (8 ones, parity 1)
    evq.delete();
    c = cyc;
    send_frame(16'hA55A, 1'b1, 1'b1, 1'b0);
    wait_cyc(20);
    check("t1_count", evq.size(), 32'd1);
    check_ev("t1", 0, c + LAT, 16'hA55A, 1'b0, 1'b0, 1'b1);
    check("t1_busy_after", 32'(rx_busy), 32'd0);

    // 2: 0x0001 needs parity 0, send 1
    evq.delete();
    c = cyc;
    send_frame(16'h0001, 1'b1, 1'b1, 1'b0);
    wait_cyc(20);
    check("t2_count", evq.size(), 32'd1);
    check_ev("t2", 0, c + LAT, 16'h0001, 1'b1, 1'b0, 1'b1);

    // 3: 30-cycle low glitch on idle line
    evq.delete();
    busy_cnt = 0;
    rx_in = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
      if (i == 29) rx_in = 1'b1;
    end
    check("t3_count", evq.size(), 32'd0);
    check("t3_busy_cycles", 32'(busy_cnt), 32'(BUSY_GLITCH));
    check("t3_busy_end", 32'(rx_busy), 32'd0);

    // 4: 0x1234 with stop=0, line held low, then recovery with 0x00FF
    evq.delete();
    c = cyc;
    send_frame(16'h1234, 1'b0, 1'b0, 1'b0);
    rx_in = 1'b0;
    wait_cyc(500);
    check("t4_count", evq.size(), 32'd1);
    check_ev("t4", 0, c + LAT, 16'h0001, 1'b0, 1'b1, 1'b0);
    check("t4_data_held", 32'(rx_data), 32'h0001);
    check("t4_busy_break", 32'(rx_busy), 32'd1);
    rx_in = 1'b1;
    wait_cyc(20);
    check("t4_busy_released", 32'(rx_busy), 32'd0);
    evq.delete();
    c = cyc;
    send_frame(16'h00FF, 1'b1, 1'b1, 1'b0);
    wait_cyc(20);
    check("t4b_count", evq.size(), 32'd1);
    check_ev("t4b", 0, c + LAT, 16'h00FF, 1'b0, 1'b0, 1'b1);

    // 5: reset in the middle of bit 7 of 0xBEEF
    evq.delete();
    drive_bit(1'b0, 1'b0);
    for (int i = 15; i > 8; i--) drive_bit(1'(16'hBEEF >> i), 1'b0);
    rx_in = 1'(16'hBEEF >> 8);
    wait_cyc(72);
    check("t5_busy_pre", 32'(rx_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_data", 32'(rx_data), 32'd0);
    check("t5_rst_busy", 32'(rx_busy), 32'd0);
    check("t5_rst_valid", 32'(rx_valid), 32'd0);
    check("t5_rst_perr", 32'(parity_err), 32'd0);
    check("t5_rst_ferr", 32'(frame_err), 32'd0);
    wait_cyc(5);
    rx_in = 1'b1;
    reset = 1'b1;
    wait_cyc(20);
    check("t5_no_strobe", evq.size(), 32'd0);
    evq.delete();
    c = cyc;
    send_frame(16'hBEEF, 1'b0, 1'b1, 1'b0);
    wait_cyc(20);
    check("t5_count", evq.size(), 32'd1);
    check_ev("t5", 0, c + LAT, 16'hBEEF, 1'b0, 1'b0, 1'b1);

    // 6: back-to-back 0xFFFF and 0x8000, mid-bit glitches in the voting build
    evq.delete();
    c = cyc;
    send_frame(16'hFFFF, 1'b1, 1'b1, GL);
    send_frame(16'h8000, 1'b0, 1'b1, GL);
    wait_cyc(50);
    check("t6_count", evq.size(), 32'd2);
    check_ev("t6a", 0, c + LAT, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    check_ev("t6b", 1, c + FRAME + LAT, 16'h8000, 1'b0, 1'b0, 1'b1);
    if (evq.size() >= 2) begin
      c2 = evq[1].cyc - evq[0].cyc;
      check("t6_spacing", c2, FRAME);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
